// File: rtl/cajero_teclado.sv
// cajero_teclado: keypad front-end for the ATM transaction controller.
// It applies a hold-off between accepted keys and forwards PIN_DIGITOS PIN
// digits as single-cycle strobes. It then accumulates a decimal amount into a
// 32-bit binary value, which is released with monto_stb when ENTER is pressed.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   tarjeta_recibida   card inserted, starts a session from IDLE
//   tecla_stb, tecla   key event (0-9 digit, A CLEAR, B ENTER, F empty)
//   cancelar           aborts a session in PIN or MONTO
//   digito_stb/digito  forwarded PIN digit
//   pin_completo       pulses together with the last PIN digit strobe
//   monto/monto_stb    accumulated amount and its final-value strobe
//   desborde           digit rejected: amount overflow or too many digits
//   ocupado            high outside IDLE
// All outputs are registered.
module cajero_teclado #(
    parameter int HOLDOFF     = 4,
    parameter int PIN_DIGITOS = 4,
    parameter int MAX_DIGITOS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tarjeta_recibida,
    input  logic        tecla_stb,
    input  logic [3:0]  tecla,
    input  logic        cancelar,
    output logic        digito_stb,
    output logic [3:0]  digito,
    output logic        pin_completo,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic        desborde,
    output logic        ocupado
);

    // The +2 keeps the widths non-zero when a parameter is 0.
    localparam int HW = $clog2(HOLDOFF + 2);
    localparam int PW = $clog2(PIN_DIGITOS + 2);
    localparam int MW = $clog2(MAX_DIGITOS + 2);

    typedef enum logic [1:0] {IDLE, PIN, MONTO, ENTREGA} estado_t;

    estado_t        estado_q, estado_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [PW-1:0]  npin_q, npin_d;
    logic [MW-1:0]  nmon_q, nmon_d;
    logic [3:0]     digito_q, digito_d;
    logic           digito_stb_q, digito_stb_d;
    logic           pin_completo_q, pin_completo_d;
    logic [31:0]    monto_q, monto_d;
    logic           monto_stb_q, monto_stb_d;
    logic           desborde_q, desborde_d;
    logic           ocupado_q, ocupado_d;

    logic           activo, aborta, acepta, es_digito, lleno, rebosa;
    logic [35:0]    base, suma;

    always_comb begin
        activo    = (estado_q == PIN) || (estado_q == MONTO);
        aborta    = activo && cancelar;
        // Only keys arriving in an active session are accepted. C-F are
        // never accepted and therefore do not restart the hold-off.
        acepta    = activo && !cancelar && tecla_stb &&
                    (hold_q == '0) && (tecla <= 4'hB);
        es_digito = (tecla <= 4'd9);
        // monto_q doubles as the accumulator. With no digits held, the base
        // is 0, so a previous session's displayed amount never leaks in.
        base      = (nmon_q == '0) ? 36'd0 : {4'd0, monto_q};
        suma      = base * 36'd10 + {32'd0, tecla};
        lleno     = (nmon_q == MW'(MAX_DIGITOS));
        rebosa    = lleno || (suma[35:32] != 4'd0);
    end

    always_comb begin
        estado_d       = estado_q;
        npin_d         = npin_q;
        nmon_d         = nmon_q;
        digito_d       = digito_q;
        monto_d        = monto_q;
        digito_stb_d   = 1'b0;
        pin_completo_d = 1'b0;
        monto_stb_d    = 1'b0;
        desborde_d     = 1'b0;

        if (aborta)
            hold_d = '0;
        else if (acepta)
            hold_d = HW'(HOLDOFF);
        else if (hold_q != '0)
            hold_d = hold_q - HW'(1);
        else
            hold_d = hold_q;

        case (estado_q)
            IDLE: begin
                if (tarjeta_recibida) begin
                    estado_d = PIN;
                    npin_d   = '0;
                    nmon_d   = '0;
                end
            end
            PIN: begin
                if (aborta) begin
                    estado_d = IDLE;
                    npin_d   = '0;
                    nmon_d   = '0;
                end else if (acepta && es_digito) begin
                    digito_d     = tecla;
                    digito_stb_d = 1'b1;
                    npin_d       = npin_q + PW'(1);
                    if (npin_q == PW'(PIN_DIGITOS - 1)) begin
                        pin_completo_d = 1'b1;
                        estado_d       = MONTO;
                        nmon_d         = '0;
                    end
                end
            end
            MONTO: begin
                if (aborta) begin
                    estado_d = IDLE;
                    npin_d   = '0;
                    nmon_d   = '0;
                end else if (acepta) begin
                    if (es_digito) begin
                        if (rebosa) begin
                            desborde_d = 1'b1;
                        end else begin
                            monto_d = suma[31:0];
                            nmon_d  = nmon_q + MW'(1);
                        end
                    end else if (tecla == 4'hA) begin
                        monto_d = '0;
                        nmon_d  = '0;
                    end else if (nmon_q != '0) begin
                        // ENTER with at least one digit held
                        estado_d    = ENTREGA;
                        monto_stb_d = 1'b1;
                    end
                end
            end
            ENTREGA: estado_d = IDLE;
            default: estado_d = IDLE;
        endcase

        ocupado_d = (estado_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q       <= IDLE;
            hold_q         <= '0;
            npin_q         <= '0;
            nmon_q         <= '0;
            digito_q       <= '0;
            digito_stb_q   <= 1'b0;
            pin_completo_q <= 1'b0;
            monto_q        <= '0;
            monto_stb_q    <= 1'b0;
            desborde_q     <= 1'b0;
            ocupado_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            hold_q         <= hold_d;
            npin_q         <= npin_d;
            nmon_q         <= nmon_d;
            digito_q       <= digito_d;
            digito_stb_q   <= digito_stb_d;
            pin_completo_q <= pin_completo_d;
            monto_q        <= monto_d;
            monto_stb_q    <= monto_stb_d;
            desborde_q     <= desborde_d;
            ocupado_q      <= ocupado_d;
        end
    end

    assign digito       = digito_q;
    assign digito_stb   = digito_stb_q;
    assign pin_completo = pin_completo_q;
    assign monto        = monto_q;
    assign monto_stb    = monto_stb_q;
    assign desborde     = desborde_q;
    assign ocupado      = ocupado_q;

endmodule

// File: doc/cajero_teclado.md
Name: cajero_teclado

Overview:
Keypad entry front-end that sits directly upstream of the ATM transaction controller. It takes raw key events from the keypad scanner, enforces a hold-off between accepted keys, and forwards exactly four PIN digits as single-cycle digit strobes. It then accumulates a decimal amount into a 32-bit binary value and presents it with a single-cycle amount strobe when ENTER is pressed.

Parameters:
HOLDOFF, 4, cycles after an accepted key during which further tecla_stb pulses are ignored (0 = no hold-off)
PIN_DIGITOS, 4, number of PIN digits forwarded per session
MAX_DIGITOS, 10, maximum decimal digits accepted for an amount

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
tarjeta_recibida  input  1  card inserted; starts a session when the block is in IDLE
tecla_stb  input  1  one-cycle pulse, tecla is valid
tecla  input  4  key code: 0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hF empty; other codes invalid
cancelar  input  1  aborts the current session
digito_stb  output  1  one-cycle pulse, PIN digit valid
digito  output  4  PIN digit value
pin_completo  output  1  one-cycle pulse in the cycle the last PIN digit strobe is issued
monto  output  32  accumulated amount in binary
monto_stb  output  1  one-cycle pulse, monto final
desborde  output  1  one-cycle pulse, a digit was rejected because of amount overflow or digit count
ocupado  output  1  high in every state except IDLE

Behaviour:
- Reset, or any cycle with reset high: state IDLE; all outputs 0; digit counters, accumulator and hold-off counter cleared. Reset overrides every other input and aborts any session in progress.
- States: IDLE, PIN, MONTO, ENTREGA.
- A key is accepted when tecla_stb=1 and the hold-off counter is 0. Accepting a key loads the counter with HOLDOFF; the counter then decrements once per cycle down to 0. A rejected pulse does not reload the counter. Codes 4'hF and 4'hC-4'hE are ignored and do not load the counter.
- IDLE: when tarjeta_recibida=1, go to PIN with the PIN count at 0. Keys received in IDLE are ignored.
- PIN:
  - An accepted digit key 0-9 in cycle N produces digito=tecla and digito_stb=1 in cycle N+1. The PIN count increments.
  - On the PIN_DIGITOS-th digit, pin_completo pulses in the same cycle as that digit_stb, and the state moves to MONTO.
  - CLEAR and ENTER are ignored in PIN.
  - digito holds its last value between strobes.
- MONTO:
  - An accepted digit d computes acc*10+d in 36-bit arithmetic.
  - If the result exceeds 2^32-1, or MAX_DIGITOS digits are already held, the digit is dropped, desborde pulses in cycle N+1, and acc is unchanged.
  - Otherwise acc is updated and monto=acc in cycle N+1.
  - CLEAR: acc=0 and digit count=0; monto reads 0 in cycle N+1.
  - ENTER with digit count ≥1: go to ENTREGA. ENTER with zero digits is ignored. An amount of 0 entered as the digit "0" counts as one digit and is valid.
- ENTREGA: monto_stb=1 for exactly one cycle with monto stable; the next state is IDLE. monto keeps its value until the next session's first digit or CLEAR.
- cancelar=1 in PIN or MONTO: go to IDLE next cycle, clear counters and acc, and emit no strobes. A key accepted in the same cycle as cancelar is discarded. cancelar in IDLE or ENTREGA has no effect.
- tarjeta_recibida while ocupado=1 is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. reset, then tarjeta_recibida; keys 1,2,3,4 each spaced 6 cycles apart -> four digito_stb pulses (digito 1,2,3,4), each one cycle after its key; pin_completo coincides with the strobe for 4; ocupado=1.
2. HOLDOFF=4: keys 5 and 6 accepted 2 cycles apart in PIN -> only 5 forwarded. Key 6 repeated 5 cycles after 5 -> forwarded.
3. After PIN, keys 2,5,0 then ENTER -> monto=250; monto_stb exactly one cycle; next state IDLE; ocupado=0.
4. Amount keys 4,2,9,4,9,6,7,2,9,5 (4294967295) then a further 0 -> desborde pulse, monto stays 4294967295. Repeat with 4,2,9,4,9,6,7,2,9,6 -> the final 6 is rejected with desborde and monto=429496729.
5. Amount keys 7,7 then CLEAR then 3 then ENTER -> monto 77, then 0, then 3; monto_stb with monto=3. ENTER pressed right after CLEAR with no digits -> ignored.
6. Reset asserted after 2 PIN digits, and separately cancelar asserted after 2 PIN digits -> IDLE, no pin_completo. A new tarjeta_recibida then requires 4 fresh digits.
